// File: rtl/mac_tile_sequencer.sv
// Sequences one convolution tile: steers upstream beats to weight load, then data load, then counts result beats.
// Optional drain watchdog enabled by defining SEQ_TIMEOUT_EN.
module mac_tile_sequencer #(
  parameter int KERNEL_SIZE    = 3,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int DATA_BEATS     = 3,
  parameter int OUT_BEATS      = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 reuse_weights,
  input  logic [BUS_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [BUS_WIDTH-1:0] w_tdata,
  output logic                 w_tvalid,
  input  logic                 w_tready,
  output logic [BUS_WIDTH-1:0] d_tdata,
  output logic                 d_tvalid,
  input  logic                 d_tready,
  input  logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 weights_loaded,
  output logic [15:0]          tile_count
);

  localparam int W_BEATS = (WEIGHT_WIDTH * KERNEL_SIZE * KERNEL_SIZE + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam logic [15:0] W_LAST = 16'(W_BEATS - 1);
  localparam logic [15:0] D_LAST = 16'(DATA_BEATS - 1);
  localparam logic [15:0] O_MAX  = 16'(OUT_BEATS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_D = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t      state_r;
  logic [15:0] wcnt_r;
  logic [15:0] dcnt_r;
  logic [15:0] ocnt_r;
  logic [15:0] tile_count_r;
  logic        weights_loaded_r;
  logic        w_hs_s;
  logic        d_hs_s;
  logic        o_hs_s;
  logic [15:0] ocnt_next_s;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_MAX = 16'(TIMEOUT_CYCLES);
  logic [15:0] wd_r;
  logic        error_r;
  assign error = error_r;
`else
  assign error = 1'b0;
`endif

  assign busy           = (state_r == LOAD_W) || (state_r == LOAD_D) || (state_r == DRAIN);
  assign done           = (state_r == DONE);
  assign weights_loaded = weights_loaded_r;
  assign tile_count     = tile_count_r;

  assign w_hs_s = (state_r == LOAD_W) && s_axis_tvalid && w_tready;
  assign d_hs_s = (state_r == LOAD_D) && s_axis_tvalid && d_tready;
  assign o_hs_s = ((state_r == LOAD_D) || (state_r == DRAIN)) && o_tvalid && o_tready;

  // Saturating result-beat count including this cycle's handshake, so DRAIN can exit on the same edge.
  always_comb begin
    ocnt_next_s = ocnt_r;
    if (o_hs_s && (ocnt_r != O_MAX)) begin
      ocnt_next_s = ocnt_r + 16'd1;
    end else begin
      ocnt_next_s = ocnt_r;
    end
  end

  // Stream steering: the active load port is wired straight through to the upstream source.
  always_comb begin
    w_tdata       = s_axis_tdata;
    d_tdata       = s_axis_tdata;
    w_tvalid      = 1'b0;
    d_tvalid      = 1'b0;
    s_axis_tready = 1'b0;
    case (state_r)
      LOAD_W: begin
        w_tvalid      = s_axis_tvalid;
        s_axis_tready = w_tready;
      end
      LOAD_D: begin
        d_tvalid      = s_axis_tvalid;
        s_axis_tready = d_tready;
      end
      default: begin
        w_tvalid      = 1'b0;
        d_tvalid      = 1'b0;
        s_axis_tready = 1'b0;
      end
    endcase
  end

  // Tile FSM with beat counters, weight residency and completion bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r          <= IDLE;
      wcnt_r           <= 16'd0;
      dcnt_r           <= 16'd0;
      ocnt_r           <= 16'd0;
      tile_count_r     <= 16'd0;
      weights_loaded_r <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_r             <= 16'd0;
      error_r          <= 1'b0;
`endif
    end else begin
      ocnt_r <= ocnt_next_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            wcnt_r <= 16'd0;
            dcnt_r <= 16'd0;
            ocnt_r <= 16'd0;
`ifdef SEQ_TIMEOUT_EN
            wd_r   <= 16'd0;
`endif
            if (reuse_weights && weights_loaded_r) begin
              state_r <= LOAD_D;
            end else begin
              weights_loaded_r <= 1'b0;
              state_r          <= LOAD_W;
            end
          end
        end
        LOAD_W: begin
          if (w_hs_s) begin
            if (wcnt_r == W_LAST) begin
              wcnt_r           <= 16'd0;
              weights_loaded_r <= 1'b1;
              state_r          <= LOAD_D;
            end else begin
              wcnt_r <= wcnt_r + 16'd1;
            end
          end
        end
        LOAD_D: begin
          if (d_hs_s) begin
            if (dcnt_r == D_LAST) begin
              dcnt_r  <= 16'd0;
              state_r <= DRAIN;
            end else begin
              dcnt_r <= dcnt_r + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (ocnt_next_s == O_MAX) begin
            state_r <= DONE;
`ifdef SEQ_TIMEOUT_EN
          end else if (o_hs_s) begin
            wd_r <= 16'd0;
          end else if ((wd_r + 16'd1) == WD_MAX) begin
            error_r          <= 1'b1;
            weights_loaded_r <= 1'b0;
            state_r          <= ERR;
          end else begin
            wd_r <= wd_r + 16'd1;
`endif
          end
        end
        DONE: begin
          tile_count_r <= tile_count_r + 16'd1;
          state_r      <= IDLE;
        end
        ERR: begin
          weights_loaded_r <= 1'b0;
          if (start) begin
            wcnt_r  <= 16'd0;
            dcnt_r  <= 16'd0;
            ocnt_r  <= 16'd0;
`ifdef SEQ_TIMEOUT_EN
            wd_r    <= 16'd0;
            error_r <= 1'b0;
`endif
            state_r <= LOAD_W;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
